// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster timing generator.
// It derives a pixel enable from the system clock by dividing it by CLK_DIV, and
// steps the horizontal/vertical position counters on that enable. Sync, active-video
// and line/frame strobes are registered alongside the counters so that all outputs
// describe the same pixel in the same cycle.
module vga_timing_gen #(
   parameter int   H_ACTIVE = 640,
   parameter int   H_FP     = 16,
   parameter int   H_SYNC   = 96,
   parameter int   H_BP     = 48,
   parameter int   V_ACTIVE = 480,
   parameter int   V_FP     = 10,
   parameter int   V_SYNC   = 2,
   parameter int   V_BP     = 33,
   parameter int   CLK_DIV  = 2,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   output logic       pix_en,
   output logic [9:0] countH,
   output logic [9:0] countV,
   output logic       hsync,
   output logic       vsync,
   output logic       inDisplay,
   output logic       line_start,
   output logic       frame_start
);

   // Line and frame lengths; both must fit the 10-bit counters (<= 1024).
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Terminal counts and window edges. The window edges are 11 bits wide because
   // a sync window ending exactly at a 1024-long line needs the value 1024.
   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
   localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

   // Divider terminal count (CLK_DIV is limited to 1..15).
   localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);

   logic [3:0] div;
   logic       tick;

   logic       h_wrap;
   logic       v_wrap;
   logic [9:0] h_nxt;
   logic [9:0] v_nxt;
   logic       hs_nxt;
   logic       vs_nxt;
   logic       de_nxt;

   // The divider reaching its last value is the cycle in which every pixel-rate
   // register updates; pix_en is the registered copy of this, so it is high in
   // exactly the cycle the new counter values become visible.
   assign tick = (div == DIV_LAST);

   // Clock divider: counts 0..CLK_DIV-1; any out-of-range value falls back to 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         div <= '0;
      else if (div >= DIV_LAST)
         div <= '0;
      else
         div <= div + 4'd1;
   end

   // Pixel enable: high for one clk per pixel (constantly high when CLK_DIV=1).
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pix_en <= 1'b0;
      else
         pix_en <= tick;
   end

   // Next raster position plus the sync/active levels that belong to it, so the
   // registered outputs never lag the counters they describe.
   always_comb begin
      h_wrap = (countH >= H_LAST);
      v_wrap = (countV >= V_LAST);
      h_nxt  = h_wrap ? 10'd0 : countH + 10'd1;
      v_nxt  = countV;
      if (h_wrap)
         v_nxt = v_wrap ? 10'd0 : countV + 10'd1;
      hs_nxt = (({1'b0, h_nxt} >= HS_START) && ({1'b0, h_nxt} < HS_END)) ? SYNC_POL : ~SYNC_POL;
      vs_nxt = (({1'b0, v_nxt} >= VS_START) && ({1'b0, v_nxt} < VS_END)) ? SYNC_POL : ~SYNC_POL;
      de_nxt = ({1'b0, h_nxt} < H_ACT) && ({1'b0, v_nxt} < V_ACT);
   end

   // Raster counters: advance once per pixel, hold otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         countH <= '0;
         countV <= '0;
      end else if (tick) begin
         countH <= h_nxt;
         countV <= v_nxt;
      end
   end

   // Sync and active-video registers, updated together with the counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hsync     <= ~SYNC_POL;
         vsync     <= ~SYNC_POL;
         inDisplay <= 1'b1;
      end else if (tick) begin
         hsync     <= hs_nxt;
         vsync     <= vs_nxt;
         inDisplay <= de_nxt;
      end
   end

   // Line/frame strobes: one clk, coincident with the pixel update that wraps the
   // counters. Leaving reset at (0,0) is not a wrap, so it produces no strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= tick & h_wrap;
         frame_start <= tick & h_wrap & v_wrap;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (full 640x480 timing at CLK_DIV=2, and
// two shrunken rasters at CLK_DIV=1/SYNC_POL=1 and CLK_DIV=3/SYNC_POL=0 so whole
// frames fit in a short run). Every cycle the stimulus process pushes the expected
// outputs, computed arithmetically from the elapsed clocks, and a monitor compares.
module tb_vga_timing_gen;

   typedef struct packed {
      logic       pe;
      logic [9:0] h;
      logic [9:0] v;
      logic       hs;
      logic       vs;
      logic       de;
      logic       ls;
      logic       fs;
   } obs_t;

   typedef struct packed {
      obs_t a;
      obs_t b;
      obs_t c;
   } exp_t;

   // Small raster: 32 x 13 (20+3+4+5, 6+2+2+3).
   localparam int SHA = 20, SHF = 3, SHS = 4, SHB = 5;
   localparam int SVA = 6,  SVF = 2, SVS = 2, SVB = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic       pe_a, hs_a, vs_a, de_a, ls_a, fs_a;
   logic       pe_b, hs_b, vs_b, de_b, ls_b, fs_b;
   logic       pe_c, hs_c, vs_c, de_c, ls_c, fs_c;
   logic [9:0] ch_a, cv_a, ch_b, cv_b, ch_c, cv_c;

   vga_timing_gen u_a (
      .clk(clk), .reset(reset), .pix_en(pe_a), .countH(ch_a), .countV(cv_a),
      .hsync(hs_a), .vsync(vs_a), .inDisplay(de_a), .line_start(ls_a), .frame_start(fs_a));

   vga_timing_gen #(
      .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
      .CLK_DIV(1), .SYNC_POL(1'b1)
   ) u_b (
      .clk(clk), .reset(reset), .pix_en(pe_b), .countH(ch_b), .countV(cv_b),
      .hsync(hs_b), .vsync(vs_b), .inDisplay(de_b), .line_start(ls_b), .frame_start(fs_b));

   vga_timing_gen #(
      .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
      .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
      .CLK_DIV(3), .SYNC_POL(1'b0)
   ) u_c (
      .clk(clk), .reset(reset), .pix_en(pe_c), .countH(ch_c), .countV(cv_c),
      .hsync(hs_c), .vsync(vs_c), .inDisplay(de_c), .line_start(ls_c), .frame_start(fs_c));

   obs_t act_a, act_b, act_c;
   assign act_a = {pe_a, ch_a, cv_a, hs_a, vs_a, de_a, ls_a, fs_a};
   assign act_b = {pe_b, ch_b, cv_b, hs_b, vs_b, de_b, ls_b, fs_b};
   assign act_c = {pe_c, ch_c, cv_c, hs_c, vs_c, de_c, ls_c, fs_c};

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   n = 0;            // clk edges since reset release
   int   ls_cnt_a = 0, fs_cnt_a = 0, fs_cnt_b = 0, fs_cnt_c = 0;

   // Reference: pixel index p = n / d; position is p wrapped by the raster size.
   function automatic obs_t model(int nn, bit r, int ha, int hf, int hs, int hb,
                                  int va, int vf, int vs, int vb, int d, bit pol);
      obs_t o;
      int   p, h, v, ht, vt;
      bit   tk;
      ht = ha + hf + hs + hb;
      vt = va + vf + vs + vb;
      if (r) begin
         o = '0;
         o.hs = !pol;
         o.vs = !pol;
         o.de = 1'b1;
         return o;
      end
      p  = nn / d;
      h  = p % ht;
      v  = (p / ht) % vt;
      tk = (nn > 0) && (nn % d == 0);
      o.pe = tk;
      o.h  = 10'(h);
      o.v  = 10'(v);
      o.hs = (h >= ha + hf && h < ha + hf + hs) ? pol : !pol;
      o.vs = (v >= va + vf && v < va + vf + vs) ? pol : !pol;
      o.de = (h < ha) && (v < va);
      o.ls = tk && (h == 0);
      o.fs = tk && (h == 0) && (v == 0);
      return o;
   endfunction

   // One clock of stimulus: advance the model at the edge, then (between edges)
   // apply the new reset level and queue what the outputs must show this cycle.
   task automatic step(input bit new_rst);
      exp_t e;
      @(posedge clk);
      if (!reset) n++;
      #2;
      reset = new_rst;
      if (new_rst) n = 0;
      e.a = model(n, reset, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0);
      e.b = model(n, reset, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1, 1'b1);
      e.c = model(n, reset, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 3, 1'b0);
      q.push_back(e);
   endtask

   task automatic check_cnt(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
      end
   endtask

   // Monitor: compare each queued expectation against the DUTs mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            checks += 3;
            if (act_a !== e.a) begin
               errors++;
               $display("FAIL sb_a t=%0t actual=%h expected=%h", $time, act_a, e.a);
            end
            if (act_b !== e.b) begin
               errors++;
               $display("FAIL sb_b t=%0t actual=%h expected=%h", $time, act_b, e.b);
            end
            if (act_c !== e.c) begin
               errors++;
               $display("FAIL sb_c t=%0t actual=%h expected=%h", $time, act_c, e.c);
            end
            if (ls_a === 1'b1) ls_cnt_a++;
            if (fs_a === 1'b1) fs_cnt_a++;
            if (fs_b === 1'b1) fs_cnt_b++;
            if (fs_c === 1'b1) fs_cnt_c++;
         end
      end
   end

   initial begin
      int guard;
      // Reset held, then an uninterrupted run covering several full-size lines and
      // many small frames.
      repeat (3) step(1'b1);
      step(1'b0);
      ls_cnt_a = 0; fs_cnt_a = 0; fs_cnt_b = 0; fs_cnt_c = 0;
      repeat (6500) step(1'b0);
      @(negedge clk); #1;
      check_cnt("line_starts_a", ls_cnt_a, n / 1600);
      check_cnt("frame_starts_a", fs_cnt_a, 0);
      check_cnt("frame_starts_b", fs_cnt_b, n / (32 * 13));
      check_cnt("frame_starts_c", fs_cnt_c, n / (32 * 13 * 3));

      // Async reset mid-line: wait until the full-size raster has just stepped to
      // countH=300, then assert reset between edges on the following cycle.
      guard = 0;
      while (!(n % 2 == 0 && (n / 2) % 800 == 300) && guard < 5000) begin
         step(1'b0);
         guard++;
      end
      check_cnt("reach_h300_bound", (guard < 5000) ? 1 : 0, 1);
      step(1'b1);
      step(1'b1);
      step(1'b0);
      ls_cnt_a = 0; fs_cnt_a = 0; fs_cnt_b = 0; fs_cnt_c = 0;
      repeat (3300) step(1'b0);
      @(negedge clk); #1;
      check_cnt("restart_line_starts_a", ls_cnt_a, n / 1600);
      check_cnt("restart_frame_starts_a", fs_cnt_a, 0);
      check_cnt("restart_frame_starts_c", fs_cnt_c, n / (32 * 13 * 3));

      // Random phase: occasional reset pulses of random length.
      for (int i = 0; i < 25000; i++) begin
         if (reset)
            step(1'($urandom_range(0, 1)));
         else
            step($urandom_range(0, 999) == 0);
      end
      step(1'b0);
      repeat (2) @(negedge clk);
      check_cnt("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
